// File: rtl/bin_a_bcd_seq_if.sv
// Handshake and display-digit bundle between the arithmetic stage, the
// sequential binary-to-BCD converter and the display scanner.
interface bin_a_bcd_seq_if;
   logic        start;
   logic [19:0] resultado;
   logic        signo_in;
   logic        busy;
   logic        done;
   logic [3:0]  dres0;
   logic [3:0]  dres1;
   logic [3:0]  dres2;
   logic [3:0]  dres3;
   logic [3:0]  dres4;
   logic [3:0]  dres5;
   logic        signo_out;
   logic        overflow;

   modport master (
      output start, resultado, signo_in,
      input  busy, done, dres0, dres1, dres2, dres3, dres4, dres5,
             signo_out, overflow
   );

   modport slave (
      input  start, resultado, signo_in,
      output busy, done, dres0, dres1, dres2, dres3, dres4, dres5,
             signo_out, overflow
   );
endinterface

// File: rtl/bin_a_bcd_seq.sv
// Sequential double-dabble converter: 20-bit magnitude to six display digits,
// with leading-zero blanking, saturation above 999999 and a sign without -0.
module bin_a_bcd_seq #(
   parameter int BLANK_LEADING = 1
) (
   input logic           clk,
   input logic           rst_n,
   bin_a_bcd_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t      r_state;
   logic [19:0] r_bin;
   logic [27:0] r_bcd;
   logic [4:0]  r_cnt;
   logic        r_sign_cap;
   logic        r_busy;
   logic        r_done;
   logic        r_ovf;
   logic        r_sign;
   logic [3:0]  r_dres [6];

   logic [27:0] w_adj;
   logic        w_ovf;
   logic        w_lead;
   logic [3:0]  w_raw;
   logic [3:0]  w_dig [6];

   // Correct every BCD nibble that would overflow past 9 when doubled.
   function automatic logic [27:0] f_add3(input logic [27:0] bcd);
      logic [27:0] res;
      res = bcd;
      for (int i = 0; i < 7; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end else begin
            res[i*4 +: 4] = bcd[i*4 +: 4];
         end
      end
      return res;
   endfunction

   assign w_adj = f_add3(r_bcd);

   // Display digits from the final accumulator: saturate on 7th digit, else blank leading zeros.
   always_comb begin
      w_ovf  = (r_bcd[27:24] != 4'd0);
      w_lead = 1'b1;
      w_raw  = 4'd0;
      for (int i = 5; i >= 0; i--) begin
         w_raw = r_bcd[i*4 +: 4];
         if (w_ovf) begin
            w_dig[i] = 4'h9;
         end else if ((BLANK_LEADING != 0) && w_lead && (i != 0) && (w_raw == 4'd0)) begin
            w_dig[i] = 4'hF;
         end else begin
            w_dig[i] = w_raw;
            w_lead   = 1'b0;
         end
      end
   end

   // Control FSM, shift datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_bin      <= 20'd0;
         r_bcd      <= 28'd0;
         r_cnt      <= 5'd0;
         r_sign_cap <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
         r_sign     <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            r_dres[i] <= 4'h0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_bin      <= bus.resultado;
                  r_sign_cap <= bus.signo_in;
                  r_bcd      <= 28'd0;
                  r_cnt      <= 5'd0;
                  r_busy     <= 1'b1;
                  r_state    <= SHIFT;
               end
            end
            SHIFT: begin
               r_bcd <= {w_adj[26:0], r_bin[19]};
               r_bin <= {r_bin[18:0], 1'b0};
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd19) begin
                  r_state <= FINISH;
               end
            end
            FINISH: begin
               for (int i = 0; i < 6; i++) begin
                  r_dres[i] <= w_dig[i];
               end
               r_ovf   <= w_ovf;
               r_sign  <= r_sign_cap & (r_bcd != 28'd0);
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.overflow  = r_ovf;
   assign bus.signo_out = r_sign;
   assign bus.dres0     = r_dres[0];
   assign bus.dres1     = r_dres[1];
   assign bus.dres2     = r_dres[2];
   assign bus.dres3     = r_dres[3];
   assign bus.dres4     = r_dres[4];
   assign bus.dres5     = r_dres[5];

endmodule

// File: tb/tb_bin_a_bcd_seq.sv
// Directed bench for bin_a_bcd_seq: blanking and non-blanking instances side by side.
module tb_bin_a_bcd_seq;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   n;
   int   bcnt;
   int   dcount;
   int   dk;
   logic [23:0] dsave;

   bin_a_bcd_seq_if bus ();
   bin_a_bcd_seq_if bus0 ();

   bin_a_bcd_seq #(.BLANK_LEADING(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   bin_a_bcd_seq #(.BLANK_LEADING(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

   logic [23:0] d1;
   logic [23:0] d0;
   assign d1 = {bus.dres5, bus.dres4, bus.dres3, bus.dres2, bus.dres1, bus.dres0};
   assign d0 = {bus0.dres5, bus0.dres4, bus0.dres3, bus0.dres2, bus0.dres1, bus0.dres0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [19:0] v, input logic s);
      bus.start      = st;
      bus.resultado  = v;
      bus.signo_in   = s;
      bus0.start     = st;
      bus0.resultado = v;
      bus0.signo_in  = s;
   endtask

   // Launch a conversion sampled at the next rising edge (edge N), leave #1 after it.
   task automatic start_conv(input logic [19:0] v, input logic s);
      @(negedge clk);
      drive(1'b1, v, s);
      @(posedge clk);
      #1;
      drive(1'b0, v, s);
   endtask

   // Step edges until done, counting edges and busy-high cycles; bounded.
   task automatic wait_done();
      n    = 0;
      bcnt = 0;
      while (!bus.done && n < 60) begin
         if (bus.busy) bcnt++;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic conv(input string tag, input logic [19:0] v, input logic s,
                       input logic [23:0] exp_d, input logic exp_sign, input logic exp_ovf);
      start_conv(v, s);
      wait_done();
      chk({tag, "_latency"}, n, 21);
      chk({tag, "_digits"}, d1, exp_d);
      chk({tag, "_sign"}, bus.signo_out, exp_sign);
      chk({tag, "_ovf"}, bus.overflow, exp_ovf);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      drive(1'b0, 20'd0, 1'b0);
      #12;
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_done", bus.done, 1'b0);
      chk("reset_digits", d1, 24'h000000);
      chk("reset_sign_ovf", {bus.signo_out, bus.overflow}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // Main example: latency, busy length, one-cycle done.
      start_conv(20'd123456, 1'b1);
      chk("busy_after_N", bus.busy, 1'b1);
      wait_done();
      chk("ex_latency", n, 21);
      chk("ex_busy_cycles", bcnt, 21);
      chk("ex_busy_low_at_done", bus.busy, 1'b0);
      chk("ex_digits", d1, 24'h123456);
      chk("ex_sign", bus.signo_out, 1'b1);
      chk("ex_ovf", bus.overflow, 1'b0);
      @(posedge clk);
      #1;
      chk("done_one_cycle", bus.done, 1'b0);
      chk("hold_digits", d1, 24'h123456);

      conv("zero", 20'd0, 1'b1, 24'hFFFFF0, 1'b0, 1'b0);
      chk("zero_noblank", d0, 24'h000000);
      conv("forty", 20'd40, 1'b0, 24'hFFFF40, 1'b0, 1'b0);
      chk("forty_noblank", d0, 24'h000040);
      conv("inner0", 20'd100005, 1'b1, 24'h100005, 1'b1, 1'b0);
      conv("max_ok", 20'd999999, 1'b0, 24'h999999, 1'b0, 1'b0);
      conv("ovf1", 20'd1000000, 1'b1, 24'h999999, 1'b1, 1'b1);
      chk("ovf1_noblank", d0, 24'h999999);
      conv("ovf_max", 20'd1048575, 1'b0, 24'h999999, 1'b0, 1'b1);

      // Restart attempt while busy is ignored.
      start_conv(20'd111, 1'b0);
      dcount = 0;
      dk     = 0;
      dsave  = 24'h0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            dcount++;
            dk    = k;
            dsave = d1;
         end
         if (k == 4) drive(1'b1, 20'd222, 1'b1);
         if (k == 5) drive(1'b0, 20'd222, 1'b1);
      end
      chk("busy_restart_count", dcount, 1);
      chk("busy_restart_edge", dk, 21);
      chk("busy_restart_value", dsave, 24'hFFF111);

      // start held high through the done cycle: back-to-back conversion.
      @(negedge clk);
      drive(1'b1, 20'd321, 1'b0);
      @(posedge clk);
      #1;
      wait_done();
      chk("b2b_first_latency", n, 21);
      chk("b2b_first_digits", d1, 24'hFFF321);
      drive(1'b1, 20'd654, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 20'd654, 1'b0);
      chk("b2b_no_gap_busy", bus.busy, 1'b1);
      wait_done();
      chk("b2b_second_latency", n, 21);
      chk("b2b_second_digits", d1, 24'hFFF654);

      // Reset mid-conversion.
      start_conv(20'd999, 1'b1);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_done", bus.done, 1'b0);
      chk("midrst_digits", d1, 24'h000000);
      chk("midrst_sign_ovf", {bus.signo_out, bus.overflow}, 2'b00);
      @(negedge clk);
      rst_n  = 1'b1;
      dcount = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) dcount++;
      end
      chk("midrst_no_done", dcount, 0);
      conv("after_rst", 20'd7, 1'b0, 24'hFFFFF7, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
